// File: rtl/md_e_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: operation
// encodings, FSM states, default latencies and the result computation.
package md_e_pkg;

  // Operation encodings carried on md_op (values 7..15 behave as MD_NONE).
  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6
  } md_op_e;

  // Unit state: idle, or counting down an accepted mult/div.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  // Default latencies in cycles of Busy.
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // Cycle counter width; latencies up to 255 cycles fit.
  localparam int CNT_W = 8;

  // Pending result: wr=0 means leave HI/LO untouched at commit (divide by zero).
  typedef struct packed {
    logic        wr;
    logic [31:0] hi;
    logic [31:0] lo;
  } md_res_t;

  // Full mult/div result for an accepted operation.
  // Signed division works on magnitudes and re-applies signs, so the
  // quotient truncates toward zero and the remainder follows the dividend.
  // The 0x80000000 / -1 case falls out naturally: magnitude quotient
  // 0x80000000 negated is 0x80000000, remainder 0.
  function automatic md_res_t md_compute(input logic [3:0]  op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    md_res_t     res;
    logic [63:0] prod;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] div_b;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    res   = '{wr: 1'b0, hi: 32'd0, lo: 32'd0};
    prod  = 64'd0;
    abs_a = 32'd0;
    abs_b = 32'd0;
    div_b = 32'd1;
    q_mag = 32'd0;
    r_mag = 32'd0;
    case (op)
      MD_MULT: begin
        prod   = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        res.wr = 1'b1;
        res.hi = prod[63:32];
        res.lo = prod[31:0];
      end
      MD_MULTU: begin
        prod   = {32'd0, a} * {32'd0, b};
        res.wr = 1'b1;
        res.hi = prod[63:32];
        res.lo = prod[31:0];
      end
      MD_DIV: begin
        abs_a  = a[31] ? (~a + 32'd1) : a;
        abs_b  = b[31] ? (~b + 32'd1) : b;
        // Substitute a divisor of 1 on zero so the datapath never sees x/0.
        div_b  = (abs_b == 32'd0) ? 32'd1 : abs_b;
        q_mag  = abs_a / div_b;
        r_mag  = abs_a % div_b;
        res.wr = (b != 32'd0);
        res.lo = (a[31] ^ b[31]) ? (~q_mag + 32'd1) : q_mag;
        res.hi = a[31] ? (~r_mag + 32'd1) : r_mag;
      end
      MD_DIVU: begin
        div_b  = (b == 32'd0) ? 32'd1 : b;
        res.wr = (b != 32'd0);
        res.lo = a / div_b;
        res.hi = a % div_b;
      end
      default: begin
        res = '{wr: 1'b0, hi: 32'd0, lo: 32'd0};
      end
    endcase
    return res;
  endfunction

endpackage

// File: rtl/md_e_if.sv
// Operand/control/result bundle between the E stage and the md unit.
interface md_e_if;
  import md_e_pkg::*;

  logic [31:0] src_a;   // rs operand (forwarded)
  logic [31:0] src_b;   // rt operand (forwarded)
  logic [3:0]  md_op;   // md_op_e encoding
  logic        start;   // op in 1..4 while not busy (combinational)
  logic        busy;    // md operation in progress
  logic [31:0] hi;      // HI register
  logic [31:0] lo;      // LO register

  modport master (
    output src_a, src_b, md_op,
    input  start, busy, hi, lo
  );

  modport slave (
    input  src_a, src_b, md_op,
    output start, busy, hi, lo
  );
endinterface

// File: rtl/md_e.sv
// E-stage multi-cycle multiply/divide unit holding HI/LO.
// The full result is computed on the accept edge and parked in tmp
// registers; HI/LO only change at the commit edge (or on mthi/mtlo in idle).
module md_e
  import md_e_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic    clk_i,
  input  logic    reset_i,
  md_e_if.slave   bus
);

  localparam logic [CNT_W-1:0] MULT_LEN = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LEN  = CNT_W'(DIV_CYCLES);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  md_res_t          tmp_q, tmp_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic             start_s;
  logic             is_mul_s;
  md_res_t          res_s;

  // Decode accept condition and the accept-time result.
  always_comb begin
    start_s  = 1'b0;
    is_mul_s = 1'b0;
    case (bus.md_op)
      MD_MULT, MD_MULTU: begin
        start_s  = (state_q == ST_IDLE);
        is_mul_s = 1'b1;
      end
      MD_DIV, MD_DIVU: begin
        start_s  = (state_q == ST_IDLE);
        is_mul_s = 1'b0;
      end
      default: begin
        start_s  = 1'b0;
        is_mul_s = 1'b0;
      end
    endcase
    res_s = md_compute(bus.md_op, bus.src_a, bus.src_b);
  end

  // Next-state logic: accept, countdown, commit and idle-time mthi/mtlo.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmp_d   = tmp_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start_s) begin
          tmp_d   = res_s;
          cnt_d   = is_mul_s ? MULT_LEN : DIV_LEN;
          state_d = ST_RUN;
        end else if (bus.md_op == MD_MTHI) begin
          hi_d = bus.src_a;
        end else if (bus.md_op == MD_MTLO) begin
          lo_d = bus.src_a;
        end else begin
          hi_d = hi_q;
          lo_d = lo_q;
        end
      end
      ST_RUN: begin
        // Any md_op while running is ignored; only the countdown matters.
        if (cnt_q <= {{(CNT_W-1){1'b0}}, 1'b1}) begin
          if (tmp_q.wr) begin
            hi_d = tmp_q.hi;
            lo_d = tmp_q.lo;
          end else begin
            hi_d = hi_q;
            lo_d = lo_q;
          end
          cnt_d   = {CNT_W{1'b0}};
          tmp_d   = '{wr: 1'b0, hi: 32'd0, lo: 32'd0};
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counter, pending result and HI/LO registers; reset aborts any op.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      tmp_q   <= '{wr: 1'b0, hi: 32'd0, lo: 32'd0};
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmp_q   <= tmp_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.start = start_s;
  assign bus.busy  = (state_q == ST_RUN);
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;

endmodule

// File: tb/tb_md_e.sv
// Directed self-checking bench for md_e.
module tb_md_e;
  import md_e_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  md_e_if mbus ();

  md_e #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk_i  (clk),
    .reset_i(rst),
    .bus    (mbus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; sample/drive 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an op for one cycle, then count Busy cycles (bounded).
  task automatic issue_and_wait(input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] b, output logic start_seen,
                                output int busy_cycles, output logic start_in_busy);
    mbus.md_op = op;
    mbus.src_a = a;
    mbus.src_b = b;
    #1;
    start_seen    = mbus.start;
    start_in_busy = 1'b0;
    busy_cycles   = 0;
    step();
    mbus.md_op = 4'd0;
    #1;
    while (mbus.busy === 1'b1 && busy_cycles < 100) begin
      if (mbus.start !== 1'b0) start_in_busy = 1'b1;
      busy_cycles++;
      step();
    end
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    mbus.md_op = 4'd0;
    mbus.src_a = 32'd0;
    mbus.src_b = 32'd0;
    step();
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (mbus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", mbus.busy); end
    checks++;
    if (mbus.hi !== 32'd0) begin errors++; $display("FAIL reset_hi got %h exp 0", mbus.hi); end
    checks++;
    if (mbus.lo !== 32'd0) begin errors++; $display("FAIL reset_lo got %h exp 0", mbus.lo); end
    checks++;
    if (mbus.start !== 1'b0) begin errors++; $display("FAIL reset_start got %b exp 0", mbus.start); end
  endtask

  task automatic test_mult();
    logic s, sb;
    int   n;
    issue_and_wait(4'd1, 32'hFFFFFFFD, 32'd5, s, n, sb);
    checks++;
    if (s !== 1'b1) begin errors++; $display("FAIL mult_start got %b exp 1", s); end
    checks++;
    if (n !== 5) begin errors++; $display("FAIL mult_busy_cycles got %0d exp 5", n); end
    checks++;
    if (sb !== 1'b0) begin errors++; $display("FAIL mult_start_in_busy got %b exp 0", sb); end
    checks++;
    if (mbus.hi !== 32'hFFFFFFFF || mbus.lo !== 32'hFFFFFFF1) begin
      errors++; $display("FAIL mult_result got %h_%h exp ffffffff_fffffff1", mbus.hi, mbus.lo);
    end
  endtask

  task automatic test_multu();
    logic s, sb;
    int   n;
    issue_and_wait(4'd2, 32'hFFFFFFFF, 32'd2, s, n, sb);
    checks++;
    if (n !== 5) begin errors++; $display("FAIL multu_busy_cycles got %0d exp 5", n); end
    checks++;
    if (mbus.hi !== 32'h00000001 || mbus.lo !== 32'hFFFFFFFE) begin
      errors++; $display("FAIL multu_result got %h_%h exp 00000001_fffffffe", mbus.hi, mbus.lo);
    end
  endtask

  task automatic test_div();
    logic s, sb;
    int   n;
    issue_and_wait(4'd3, 32'hFFFFFFF9, 32'd2, s, n, sb);
    checks++;
    if (s !== 1'b1) begin errors++; $display("FAIL div_start got %b exp 1", s); end
    checks++;
    if (n !== 10) begin errors++; $display("FAIL div_busy_cycles got %0d exp 10", n); end
    checks++;
    if (mbus.hi !== 32'hFFFFFFFF || mbus.lo !== 32'hFFFFFFFD) begin
      errors++; $display("FAIL div_result got %h_%h exp ffffffff_fffffffd", mbus.hi, mbus.lo);
    end
    // Back-to-back: divu accepted the cycle right after the previous commit.
    issue_and_wait(4'd4, 32'd7, 32'd2, s, n, sb);
    checks++;
    if (s !== 1'b1 || n !== 10) begin
      errors++; $display("FAIL divu_timing got start=%b cycles=%0d exp start=1 cycles=10", s, n);
    end
    checks++;
    if (mbus.hi !== 32'd1 || mbus.lo !== 32'd3) begin
      errors++; $display("FAIL divu_result got %h_%h exp 00000001_00000003", mbus.hi, mbus.lo);
    end
    issue_and_wait(4'd3, 32'h80000000, 32'hFFFFFFFF, s, n, sb);
    checks++;
    if (mbus.hi !== 32'd0 || mbus.lo !== 32'h80000000) begin
      errors++; $display("FAIL div_overflow got %h_%h exp 00000000_80000000", mbus.hi, mbus.lo);
    end
  endtask

  task automatic test_mthi_mtlo_divzero();
    logic s, sb;
    int   n;
    mbus.md_op = 4'd5;
    mbus.src_a = 32'h1234;
    #1;
    checks++;
    if (mbus.start !== 1'b0) begin errors++; $display("FAIL mthi_start got %b exp 0", mbus.start); end
    step();
    mbus.md_op = 4'd6;
    mbus.src_a = 32'h5678;
    #1;
    checks++;
    if (mbus.hi !== 32'h1234 || mbus.busy !== 1'b0) begin
      errors++; $display("FAIL mthi_value got hi=%h busy=%b exp hi=00001234 busy=0", mbus.hi, mbus.busy);
    end
    step();
    mbus.md_op = 4'd7;   // unused encoding behaves as none
    mbus.src_a = 32'hDEAD;
    #1;
    checks++;
    if (mbus.lo !== 32'h5678 || mbus.start !== 1'b0) begin
      errors++; $display("FAIL mtlo_value got lo=%h start=%b exp lo=00005678 start=0", mbus.lo, mbus.start);
    end
    step();
    checks++;
    if (mbus.hi !== 32'h1234 || mbus.lo !== 32'h5678 || mbus.busy !== 1'b0) begin
      errors++; $display("FAIL op7_noop got %h_%h busy=%b exp 00001234_00005678 busy=0", mbus.hi, mbus.lo, mbus.busy);
    end
    issue_and_wait(4'd3, 32'd99, 32'd0, s, n, sb);
    checks++;
    if (n !== 10) begin errors++; $display("FAIL divzero_busy_cycles got %0d exp 10", n); end
    checks++;
    if (mbus.hi !== 32'h1234 || mbus.lo !== 32'h5678) begin
      errors++; $display("FAIL divzero_keep got %h_%h exp 00001234_00005678", mbus.hi, mbus.lo);
    end
  endtask

  task automatic test_busy_conflict();
    int n;
    mbus.md_op = 4'd1;
    mbus.src_a = 32'h00010000;
    mbus.src_b = 32'h00030000;
    step();
    n = 0;
    for (int i = 1; i <= 5; i++) begin
      if (i == 2) begin
        mbus.md_op = 4'd5; mbus.src_a = 32'hAAAA;
      end else if (i == 4) begin
        mbus.md_op = 4'd1; mbus.src_a = 32'd9; mbus.src_b = 32'd9;
      end else begin
        mbus.md_op = 4'd0;
      end
      #1;
      if (mbus.busy === 1'b1) n++;
      checks++;
      if (mbus.start !== 1'b0) begin errors++; $display("FAIL conflict_start c%0d got %b exp 0", i, mbus.start); end
      if (i == 3) begin
        checks++;
        if (mbus.hi !== 32'h1234) begin errors++; $display("FAIL conflict_mthi_ignored got %h exp 00001234", mbus.hi); end
      end
      step();
    end
    mbus.md_op = 4'd0;
    #1;
    checks++;
    if (n !== 5 || mbus.busy !== 1'b0) begin
      errors++; $display("FAIL conflict_busy got cycles=%0d busy=%b exp 5/0", n, mbus.busy);
    end
    checks++;
    if (mbus.hi !== 32'd3 || mbus.lo !== 32'd0) begin
      errors++; $display("FAIL conflict_result got %h_%h exp 00000003_00000000", mbus.hi, mbus.lo);
    end
  endtask

  task automatic test_reset_midop();
    logic s, sb;
    int   n;
    mbus.md_op = 4'd3;
    mbus.src_a = 32'd100;
    mbus.src_b = 32'd7;
    step();
    mbus.md_op = 4'd0;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (mbus.busy !== 1'b0 || mbus.hi !== 32'd0 || mbus.lo !== 32'd0) begin
      errors++; $display("FAIL midreset got busy=%b %h_%h exp 0 00000000_00000000", mbus.busy, mbus.hi, mbus.lo);
    end
    for (int i = 0; i < 12; i++) step();
    checks++;
    if (mbus.hi !== 32'd0 || mbus.lo !== 32'd0) begin
      errors++; $display("FAIL midreset_no_commit got %h_%h exp 00000000_00000000", mbus.hi, mbus.lo);
    end
    issue_and_wait(4'd1, 32'd3, 32'd4, s, n, sb);
    checks++;
    if (s !== 1'b1 || n !== 5 || mbus.hi !== 32'd0 || mbus.lo !== 32'd12) begin
      errors++; $display("FAIL post_reset_mult got start=%b cycles=%0d %h_%h exp 1 5 00000000_0000000c",
                         s, n, mbus.hi, mbus.lo);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_mthi_mtlo_divzero();
    test_busy_conflict();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
